multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore-style controller that sequences the multicycle MIPS datapath: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
//  Consumes op/funct from the instruction register and drives every datapath strobe and mux select.
//  Inserts one interrupt-fetch cycle at instruction boundaries and flags unsupported opcodes.
// PARAMETERS
//  INT_EN   1  1 = honour irq; 0 = irq ignored, INTR state unreachable
//  STATE_W  4  state register width
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high
//  op           in   6  instr[31:26] from instruction register
//  funct        in   6  instr[5:0] from instruction register
//  irq          in   1  level interrupt request
//  aluControl   out  2  00 ADD, 01 SUB, 10 AND, 11 OR
//  aluSrcB      out  2  00 B reg, 01 const 4, 10 signImm, 11 signImm<<2
//  pcSource     out  2  00 aluResult, 01 aluOut, 10 jump target, 11 zero
//  aluSrcA, regWrite, regDst, isInterrupted, isBranch, pcWrite, lorD, memWrite, memToReg, IrWrite  out 1 each
//  irq_ack      out  1  one-cycle pulse in INTR
//  illegal_op   out  1  one-cycle pulse when DECODE sees an unsupported op/funct
//  retire       out  1  one-cycle pulse in the last state of each instruction
//  state_dbg    out  STATE_W  current state
// BEHAVIOUR
//  - Reset high: state <= FETCH at the next edge; all 1-bit outputs = 0; 2-bit outputs = 00 during the reset cycle. Reset mid-instruction abandons that instruction with no reg/mem write.
//  - Outputs decode from state only. Exception: EXEC, where aluControl decodes funct.
//  - Strobes not listed for a state are 0; 2-bit selects not listed are 00.
//  - FETCH: lorD=0, aluSrcA=0, aluSrcB=01, ADD, IrWrite=1, pcWrite=1, pcSource=00 -> DECODE.
//  - DECODE: aluSrcA=0, aluSrcB=11, ADD (branch target into aluOut). Next state by op:
//    * 000000 (R-type) -> EXEC
//    * 100011 (lw) or 101011 (sw) -> MEMADR
//    * 000100 (beq) -> BRANCH
//    * 001000 (addi) -> ADDIEX
//    * 000010 (j) -> JUMP
//    * any other op -> FETCH, with illegal_op=1
//  - MEMADR: aluSrcA=1, aluSrcB=10, ADD -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD: lorD=1 -> MEMWB.
//  - MEMWB: regDst=0, memToReg=1, regWrite=1, retire -> FETCH.
//  - MEMWR: lorD=1, memWrite=1, retire -> FETCH.
//  - EXEC: aluSrcA=1, aluSrcB=00; funct 0x20/0x22/0x24/0x25 -> ADD/SUB/AND/OR, then ALUWB.
//    Any other funct -> FETCH with illegal_op=1, and no ALUWB.
//  - ALUWB: regDst=1, memToReg=0, regWrite=1, retire -> FETCH.
//  - BRANCH: aluSrcA=1, aluSrcB=00, SUB, isBranch=1, pcSource=01, retire -> FETCH.
//    PC updates only if zero; the datapath does the gating.
//  - ADDIEX: aluSrcA=1, aluSrcB=10, ADD -> ADDIWB.
//  - ADDIWB: regDst=0, memToReg=0, regWrite=1, retire -> FETCH.
//  - JUMP: pcWrite=1, pcSource=10, retire -> JUMP exits to FETCH.
//  - Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - Interrupt:
//    * irq is sampled only on the edge leaving a retire state or an illegal_op cycle.
//    * If INT_EN && irq at that edge: go to INTR instead of FETCH.
//    * INTR = FETCH strobes with isInterrupted=1 and pcWrite=0, so PC keeps the return address. Also irq_ack=1 -> DECODE.
//    * isInterrupted is 1 only in INTR.
//    * irq asserted mid-instruction waits for the boundary.
//    * irq still high after INTR: one further instruction completes before the next INTR. There are no back-to-back INTRs.
//  - Reset and irq together: reset wins.
//  - Undefined state encodings -> FETCH.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct codes, ALU_ADD/SUB/AND/OR, aluSrcB/pcSource encodings, state encodings.
//  - Sub-module alu_decoder: funct -> {aluControl, funct_valid}. Combinational, used in EXEC.
//  - The state register is the only sequential element.
// TESTING
//  - Reset: 3 cycles high -> all strobes 0; first cycle after release is FETCH with IrWrite=1, pcWrite=1, aluSrcB=01.
//  - lw (op 100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regWrite=1 and memToReg=1 only in cycle 5; retire in cycle 5.
//  - R-type, each funct 0x20/0x22/0x24/0x25: aluControl = 00/01/10/11 in EXEC; regDst=1 with regWrite in ALUWB. Funct 0x2A -> illegal_op pulse, no regWrite.
//  - beq then j: isBranch=1 with pcSource=01 in cycle 3; j gives pcWrite=1 with pcSource=10 in cycle 3. Each instruction then returns to FETCH.
//  - irq raised during MEMRD of lw: MEMWB completes, then INTR (isInterrupted=1, irq_ack=1, pcWrite=0), then DECODE. With INT_EN=0: FETCH follows.
//  - Reset asserted in MEMWR: memWrite=0 that cycle; FETCH after release. Op 111111 -> illegal_op, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_ctrl_pkg
//  Description : Shared opcodes, funct codes, ALU/mux encodings and state
//                encodings for the multicycle MIPS control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states; encodings 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_INTR   = 4'd12
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps an R-type funct field to the 2-bit ALU control and
//                reports whether the funct is one the datapath supports.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] aluControl,
    output logic       funct_valid
);

    // Unsupported funct codes fall back to ADD and are flagged invalid
    always_comb begin
        aluControl  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FUNCT_ADD: aluControl = ALU_ADD;
            FUNCT_SUB: aluControl = ALU_SUB;
            FUNCT_AND: aluControl = ALU_AND;
            FUNCT_OR:  aluControl = ALU_OR;
            default:   funct_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Moore controller for the multicycle MIPS datapath. Walks
//                FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives every datapath
//                strobe and mux select, inserts an interrupt-fetch cycle at
//                instruction boundaries and flags unsupported opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit INT_EN  = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               irq,
    output logic [1:0]         aluControl,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         pcSource,
    output logic               aluSrcA,
    output logic               regWrite,
    output logic               regDst,
    output logic               isInterrupted,
    output logic               isBranch,
    output logic               pcWrite,
    output logic               lorD,
    output logic               memWrite,
    output logic               memToReg,
    output logic               IrWrite,
    output logic               irq_ack,
    output logic               illegal_op,
    output logic               retire,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     r_state;
    state_t     w_boundaryNext;
    logic [1:0] w_execAluControl;
    logic       w_functValid;
    logic       w_opValid;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .aluControl  (w_execAluControl),
        .funct_valid (w_functValid)
    );

    // Where to go after the last cycle of an instruction (or an illegal one)
    assign w_boundaryNext = (INT_EN && irq) ? S_INTR : S_FETCH;

    // Opcodes that DECODE knows how to dispatch
    assign w_opValid = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                       (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);

    assign state_dbg = STATE_W'(r_state);

    // State register and next-state sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_INTR:   r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= w_boundaryNext;
                    endcase
                end
                S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXEC:   r_state <= w_functValid ? S_ALUWB : w_boundaryNext;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_MEMWR, S_ALUWB,
                S_BRANCH, S_ADDIWB, S_JUMP:
                          r_state <= w_boundaryNext;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Output decode from the current state; everything quiet while in reset
    always_comb begin
        aluControl    = ALU_ADD;
        aluSrcB       = SRCB_REG;
        pcSource      = PCSRC_ALU;
        aluSrcA       = 1'b0;
        regWrite      = 1'b0;
        regDst        = 1'b0;
        isInterrupted = 1'b0;
        isBranch      = 1'b0;
        pcWrite       = 1'b0;
        lorD          = 1'b0;
        memWrite      = 1'b0;
        memToReg      = 1'b0;
        IrWrite       = 1'b0;
        irq_ack       = 1'b0;
        illegal_op    = 1'b0;
        retire        = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    aluSrcB = SRCB_FOUR;
                    IrWrite = 1'b1;
                    pcWrite = 1'b1;
                end
                // Same fetch as FETCH but PC is held so it keeps the return address
                S_INTR: begin
                    aluSrcB       = SRCB_FOUR;
                    IrWrite       = 1'b1;
                    isInterrupted = 1'b1;
                    irq_ack       = 1'b1;
                end
                S_DECODE: begin
                    aluSrcB    = SRCB_IMMSH;
                    illegal_op = !w_opValid;
                end
                S_MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    lorD = 1'b1;
                end
                S_MEMWB: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWR: begin
                    lorD     = 1'b1;
                    memWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_EXEC: begin
                    aluSrcA    = 1'b1;
                    aluControl = w_execAluControl;
                    illegal_op = !w_functValid;
                end
                S_ALUWB: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                // PC update is gated on the zero flag in the datapath
                S_BRANCH: begin
                    aluSrcA    = 1'b1;
                    aluControl = ALU_SUB;
                    isBranch   = 1'b1;
                    pcSource   = PCSRC_ALUOUT;
                    retire     = 1'b1;
                end
                S_ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                S_ADDIWB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = PCSRC_JUMP;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Directed, table-driven bench for multicycle_control_fsm plus
//                hand-written interrupt and reset corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       irq;

    // DUT with interrupts enabled
    logic [1:0] aluControl, aluSrcB, pcSource;
    logic       aluSrcA, regWrite, regDst, isInterrupted, isBranch, pcWrite;
    logic       lorD, memWrite, memToReg, IrWrite, irq_ack, illegal_op, retire;
    logic [3:0] state_dbg;

    // DUT with interrupts disabled
    logic [1:0] aluControl0, aluSrcB0, pcSource0;
    logic       aluSrcA0, regWrite0, regDst0, isInterrupted0, isBranch0, pcWrite0;
    logic       lorD0, memWrite0, memToReg0, IrWrite0, irq_ack0, illegal_op0, retire0;
    logic [3:0] state_dbg0;

    multicycle_control_fsm #(.INT_EN(1'b1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .irq(irq),
        .aluControl(aluControl), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .aluSrcA(aluSrcA), .regWrite(regWrite), .regDst(regDst),
        .isInterrupted(isInterrupted), .isBranch(isBranch), .pcWrite(pcWrite),
        .lorD(lorD), .memWrite(memWrite), .memToReg(memToReg), .IrWrite(IrWrite),
        .irq_ack(irq_ack), .illegal_op(illegal_op), .retire(retire),
        .state_dbg(state_dbg)
    );

    multicycle_control_fsm #(.INT_EN(1'b0), .STATE_W(4)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .irq(irq),
        .aluControl(aluControl0), .aluSrcB(aluSrcB0), .pcSource(pcSource0),
        .aluSrcA(aluSrcA0), .regWrite(regWrite0), .regDst(regDst0),
        .isInterrupted(isInterrupted0), .isBranch(isBranch0), .pcWrite(pcWrite0),
        .lorD(lorD0), .memWrite(memWrite0), .memToReg(memToReg0), .IrWrite(IrWrite0),
        .irq_ack(irq_ack0), .illegal_op(illegal_op0), .retire(retire0),
        .state_dbg(state_dbg0)
    );

    always #5 clk = ~clk;

    // Observed bundle: {state[22:19], aluControl, aluSrcB, pcSource, 13 strobes}
    logic [22:0] act, act0;
    assign act  = {state_dbg, aluControl, aluSrcB, pcSource, aluSrcA, regWrite, regDst,
                   isInterrupted, isBranch, pcWrite, lorD, memWrite, memToReg, IrWrite,
                   irq_ack, illegal_op, retire};
    assign act0 = {state_dbg0, aluControl0, aluSrcB0, pcSource0, aluSrcA0, regWrite0, regDst0,
                   isInterrupted0, isBranch0, pcWrite0, lorD0, memWrite0, memToReg0, IrWrite0,
                   irq_ack0, illegal_op0, retire0};

    // Strobe bits and field placements inside the 19-bit output part
    localparam logic [18:0] RET  = 19'h00001;
    localparam logic [18:0] ILL  = 19'h00002;
    localparam logic [18:0] ACK  = 19'h00004;
    localparam logic [18:0] IRW  = 19'h00008;
    localparam logic [18:0] M2R  = 19'h00010;
    localparam logic [18:0] MW   = 19'h00020;
    localparam logic [18:0] LORD = 19'h00040;
    localparam logic [18:0] PCW  = 19'h00080;
    localparam logic [18:0] BR   = 19'h00100;
    localparam logic [18:0] INTF = 19'h00200;
    localparam logic [18:0] RDST = 19'h00400;
    localparam logic [18:0] RW   = 19'h00800;
    localparam logic [18:0] ASA  = 19'h01000;
    localparam logic [18:0] PCS_AO = 19'h02000;   // pcSource 01
    localparam logic [18:0] PCS_J  = 19'h04000;   // pcSource 10
    localparam logic [18:0] SB_4   = 19'h08000;   // aluSrcB 01
    localparam logic [18:0] SB_IMM = 19'h10000;   // aluSrcB 10
    localparam logic [18:0] SB_SH  = 19'h18000;   // aluSrcB 11
    localparam logic [18:0] A_SUB  = 19'h20000;   // aluControl 01
    localparam logic [18:0] A_AND  = 19'h40000;   // aluControl 10
    localparam logic [18:0] A_OR   = 19'h60000;   // aluControl 11

    // Hand-derived per-state output expectations
    localparam logic [18:0] E_FETCH  = IRW | PCW | SB_4;
    localparam logic [18:0] E_DECODE = SB_SH;
    localparam logic [18:0] E_MEMADR = ASA | SB_IMM;
    localparam logic [18:0] E_MEMRD  = LORD;
    localparam logic [18:0] E_MEMWB  = M2R | RW | RET;
    localparam logic [18:0] E_MEMWR  = LORD | MW | RET;
    localparam logic [18:0] E_EXEC   = ASA;
    localparam logic [18:0] E_ALUWB  = RDST | RW | RET;
    localparam logic [18:0] E_BRANCH = ASA | A_SUB | BR | PCS_AO | RET;
    localparam logic [18:0] E_ADDIEX = ASA | SB_IMM;
    localparam logic [18:0] E_ADDIWB = RW | RET;
    localparam logic [18:0] E_JUMP   = PCW | PCS_J | RET;
    localparam logic [18:0] E_INTR   = SB_4 | IRW | INTF | ACK;

    localparam logic [18:0] M_ALL   = 19'h7FFFF;
    localparam logic [18:0] M_NOALU = 19'h1FFFF;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        irq;
        logic [22:0] exp;
        logic [22:0] mask;
    } vec_t;

    vec_t vq[$];
    int   nVec = 0;
    int   nErr = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic i, input logic [3:0] st, input logic chkSt,
                       input logic [18:0] e, input logic [18:0] m);
        vec_t v;
        v.rst  = r;
        v.op   = o;
        v.fn   = f;
        v.irq  = i;
        v.exp  = {st, e};
        v.mask = {chkSt ? 4'hF : 4'h0, m};
        vq.push_back(v);
    endtask

    // Apply inputs for one cycle and move to the sampling point (falling edge)
    task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic i);
        reset = r;
        op    = o;
        funct = f;
        irq   = i;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [22:0] a, input logic [22:0] e,
                       input logic [22:0] m);
        nVec++;
        if ((a & m) !== (e & m)) begin
            nErr++;
            $display("FAIL %s: got state/outputs %h, expected %h (mask %h)", nm, a, e, m);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op = '0; funct = '0; irq = 1'b0;

        // ---- table: reset, then every instruction class in turn ----
        add(1, OP_RTYPE, 0, 0, S_FETCH, 0, '0, M_ALL);
        add(1, OP_RTYPE, 0, 0, S_FETCH, 1, '0, M_ALL);
        add(1, OP_RTYPE, 0, 0, S_FETCH, 1, '0, M_ALL);
        // lw
        add(0, OP_LW, 0, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_LW, 0, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_LW, 0, 0, S_MEMADR, 1, E_MEMADR, M_ALL);
        add(0, OP_LW, 0, 0, S_MEMRD,  1, E_MEMRD,  M_ALL);
        add(0, OP_LW, 0, 0, S_MEMWB,  1, E_MEMWB,  M_ALL);
        // sw
        add(0, OP_SW, 0, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_SW, 0, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_SW, 0, 0, S_MEMADR, 1, E_MEMADR, M_ALL);
        add(0, OP_SW, 0, 0, S_MEMWR,  1, E_MEMWR,  M_ALL);
        // R-type, four supported functs
        add(0, OP_RTYPE, FUNCT_ADD, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_RTYPE, FUNCT_ADD, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_RTYPE, FUNCT_ADD, 0, S_EXEC,   1, E_EXEC,   M_ALL);
        add(0, OP_RTYPE, FUNCT_ADD, 0, S_ALUWB,  1, E_ALUWB,  M_ALL);
        add(0, OP_RTYPE, FUNCT_SUB, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_RTYPE, FUNCT_SUB, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_RTYPE, FUNCT_SUB, 0, S_EXEC,   1, E_EXEC | A_SUB, M_ALL);
        add(0, OP_RTYPE, FUNCT_SUB, 0, S_ALUWB,  1, E_ALUWB,  M_ALL);
        add(0, OP_RTYPE, FUNCT_AND, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_RTYPE, FUNCT_AND, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_RTYPE, FUNCT_AND, 0, S_EXEC,   1, E_EXEC | A_AND, M_ALL);
        add(0, OP_RTYPE, FUNCT_AND, 0, S_ALUWB,  1, E_ALUWB,  M_ALL);
        add(0, OP_RTYPE, FUNCT_OR,  0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_RTYPE, FUNCT_OR,  0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_RTYPE, FUNCT_OR,  0, S_EXEC,   1, E_EXEC | A_OR, M_ALL);
        add(0, OP_RTYPE, FUNCT_OR,  0, S_ALUWB,  1, E_ALUWB,  M_ALL);
        // R-type slt (unsupported): illegal pulse in EXEC, straight back to FETCH
        add(0, OP_RTYPE, 6'h2A, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_RTYPE, 6'h2A, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_RTYPE, 6'h2A, 0, S_EXEC,   1, ASA | ILL, M_NOALU);
        // beq
        add(0, OP_BEQ, 0, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_BEQ, 0, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_BEQ, 0, 0, S_BRANCH, 1, E_BRANCH, M_ALL);
        // j
        add(0, OP_J, 0, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_J, 0, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_J, 0, 0, S_JUMP,   1, E_JUMP,   M_ALL);
        // addi
        add(0, OP_ADDI, 0, 0, S_FETCH,  1, E_FETCH,  M_ALL);
        add(0, OP_ADDI, 0, 0, S_DECODE, 1, E_DECODE, M_ALL);
        add(0, OP_ADDI, 0, 0, S_ADDIEX, 1, E_ADDIEX, M_ALL);
        add(0, OP_ADDI, 0, 0, S_ADDIWB, 1, E_ADDIWB, M_ALL);
        // unsupported opcode 111111: illegal in DECODE, then FETCH
        add(0, 6'b111111, 0, 0, S_FETCH,  1, E_FETCH,        M_ALL);
        add(0, 6'b111111, 0, 0, S_DECODE, 1, E_DECODE | ILL, M_ALL);
        add(0, OP_J,      0, 0, S_FETCH,  1, E_FETCH,        M_ALL);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].op, vq[i].fn, vq[i].irq);
            chk($sformatf("vec%0d", i), act, vq[i].exp, vq[i].mask);
            nextCycle();
        end

        // ---- irq raised during MEMRD of lw, held high for a while ----
        drive(1, OP_LW, 0, 0);
        chk("irq_rst", act, 23'd0, {4'h0, M_ALL});
        nextCycle();
        drive(0, OP_LW, 0, 0); chk("irq_fetch", act, {S_FETCH, E_FETCH}, '1); nextCycle();
        drive(0, OP_LW, 0, 0); chk("irq_decode", act, {S_DECODE, E_DECODE}, '1); nextCycle();
        drive(0, OP_LW, 0, 0); chk("irq_memadr", act, {S_MEMADR, E_MEMADR}, '1); nextCycle();
        drive(0, OP_LW, 0, 1); chk("irq_memrd", act, {S_MEMRD, E_MEMRD}, '1); nextCycle();
        drive(0, OP_LW, 0, 1);
        chk("irq_memwb_waits", act, {S_MEMWB, E_MEMWB}, '1);
        chk("irq_memwb_noint", act0, {S_MEMWB, E_MEMWB}, '1);
        nextCycle();
        drive(0, OP_ADDI, 0, 1);
        chk("irq_intr", act, {S_INTR, E_INTR}, '1);
        chk("irq_noint_fetch", act0, {S_FETCH, E_FETCH}, '1);
        nextCycle();
        drive(0, OP_ADDI, 0, 1);
        chk("irq_after_intr_decode", act, {S_DECODE, E_DECODE}, '1);
        chk("irq_noint_decode", act0, {S_DECODE, E_DECODE}, '1);
        nextCycle();
        drive(0, OP_ADDI, 0, 1); chk("irq_addiex", act, {S_ADDIEX, E_ADDIEX}, '1); nextCycle();
        drive(0, OP_ADDI, 0, 1); chk("irq_addiwb", act, {S_ADDIWB, E_ADDIWB}, '1); nextCycle();
        drive(0, OP_ADDI, 0, 0);
        chk("irq_second_intr", act, {S_INTR, E_INTR}, '1);
        chk("irq_noint_second", act0, {S_FETCH, E_FETCH}, '1);
        nextCycle();
        drive(0, OP_ADDI, 0, 0); chk("irq_resume_decode", act, {S_DECODE, E_DECODE}, '1); nextCycle();

        // ---- reset asserted in MEMWR of sw, with irq high at the same edge ----
        drive(1, OP_SW, 0, 0); chk("rst_sw_pre", act, 23'd0, {4'h0, M_ALL}); nextCycle();
        drive(0, OP_SW, 0, 0); chk("sw_fetch", act, {S_FETCH, E_FETCH}, '1); nextCycle();
        drive(0, OP_SW, 0, 0); chk("sw_decode", act, {S_DECODE, E_DECODE}, '1); nextCycle();
        drive(0, OP_SW, 0, 0); chk("sw_memadr", act, {S_MEMADR, E_MEMADR}, '1); nextCycle();
        drive(1, OP_SW, 0, 1);
        chk("rst_in_memwr", act, {S_MEMWR, 19'd0}, '1);
        nextCycle();
        drive(0, OP_SW, 0, 0);
        chk("rst_wins_fetch", act, {S_FETCH, E_FETCH}, '1);
        chk("rst_wins_fetch_noint", act0, {S_FETCH, E_FETCH}, '1);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
